// File: rtl/logic_unit_serial.sv
// logic_unit_serial: multi-cycle AND/OR/XOR/NOR unit, SLICE bits per cycle, start/ready handshake
// Optional LOGIC_FLAGS_EN adds flag_zero/flag_parity accumulated over the result slices
module logic_unit_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy
`ifdef LOGIC_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_parity
`endif
);
  localparam int N = WIDTH / SLICE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0] op_r;
  logic [SLICE-1:0] a_s, b_s, r_s;
  logic accept;
  int idx;
  assign accept = ctrl_start && state != RUN;
  assign busy = state == RUN;
  assign data_resultRDY = state == DONE;
  assign idx = int'(cnt) * SLICE;
  assign a_s = a_r[idx +: SLICE];
  assign b_s = b_r[idx +: SLICE];
  always_comb begin
    r_s = op_r == 2'b00 ? a_s & b_s :
          op_r == 2'b01 ? a_s | b_s :
          op_r == 2'b10 ? a_s ^ b_s : ~(a_s | b_s);
    state_nx = state == RUN ? (cnt == LAST ? DONE : RUN) : (ctrl_start ? RUN : IDLE);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      data_result <= '0;
`ifdef LOGIC_FLAGS_EN
      flag_zero <= 1'b0;
      flag_parity <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= data_operandA;
        b_r <= data_operandB;
        op_r <= ctrl_op;
        cnt <= '0;
        data_result <= '0;
`ifdef LOGIC_FLAGS_EN
        flag_zero <= 1'b1;
        flag_parity <= 1'b0;
`endif
      end else if (state == RUN) begin
        data_result[idx +: SLICE] <= r_s;
        cnt <= cnt + 1'b1;
`ifdef LOGIC_FLAGS_EN
        flag_zero <= flag_zero & (r_s == '0);
        flag_parity <= flag_parity ^ (^r_s);
`endif
      end
    end
  end
endmodule
